// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin slice arbiter.
// Optional feature macro used by the arbiter: RR_ARB_LOCK_EN (owner slice extension).
package rr_arb_pkg;

    localparam int MAX_N     = 16;
    localparam int MAX_ID_W  = 4;
    localparam int MIN_SLICE = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // First set bit of req at or after start, wrapping modulo n (bits >= n ignored).
    function automatic logic [MAX_ID_W-1:0] next_req(
        input logic [MAX_N-1:0]    req,
        input logic [MAX_ID_W-1:0] start,
        input int unsigned         n
    );
        logic [MAX_ID_W-1:0] idx;
        logic                found;
        logic [MAX_ID_W:0]   pos;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            pos = {1'b0, start} + (MAX_ID_W+1)'(k);
            if (pos >= (MAX_ID_W+1)'(n)) begin
                pos = pos - (MAX_ID_W+1)'(n);
            end
            if (!found && (k < n) && req[pos[MAX_ID_W-1:0]]) begin
                idx   = pos[MAX_ID_W-1:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational masked priority picker: first request at or after ptr, wrapping.
// Shared by the arbiter's idle-start and hand-off selection.
module rr_prio_pick
    import rr_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    onehot,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    // Rotating search from ptr; onehot is all-zero when nothing is requested.
    always_comb begin
        idx    = ID_W'(next_req(MAX_N'(req), MAX_ID_W'(ptr), N));
        any    = |req;
        onehot = '0;
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_slice_arbiter.sv
// N-way round-robin arbiter with per-requester programmable time slice.
// Registered one-hot grant; direct owner-to-owner hand-off with no idle cycle.
// Optional macro RR_ARB_LOCK_EN adds the lock input (owner holds past slice expiry).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | no owner; next request found from ptr
// ARB_BUSY | owner own_q holds the grant; cnt_q counts cycles up to lim_q
module rr_slice_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int SLICE_W = 4,
    parameter int ID_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*SLICE_W-1:0] slice_len,
`ifdef RR_ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [N-1:0]         gnt,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 gnt_vld
);

    localparam logic [SLICE_W:0]   CNT_ONE = (SLICE_W+1)'(MIN_SLICE);
    localparam logic [SLICE_W-1:0] LIM_MIN = SLICE_W'(MIN_SLICE);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     own_q, own_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [SLICE_W:0]    cnt_q, cnt_d;
    logic [SLICE_W-1:0]  lim_q, lim_d;
    logic [N-1:0]        gnt_d;
    logic [ID_W-1:0]     gnt_id_d;

    logic [ID_W-1:0]     own_inc;
    logic [ID_W-1:0]     pick_ptr;
    logic [N-1:0]        pick_onehot;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic [SLICE_W-1:0]  pick_slice;
    logic [SLICE_W-1:0]  own_slice;
    logic                own_req;
    logic                others;
    logic                at_lim;
    logic                expire;

    rr_prio_pick #(
        .N    (N),
        .ID_W (ID_W)
    ) u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Owner-relative quantities and the picker start point (ptr when idle, owner+1 when busy).
    always_comb begin
        own_inc    = (own_q == ID_W'(N-1)) ? '0 : own_q + 1'b1;
        pick_ptr   = (state_q == ARB_IDLE) ? ptr_q : own_inc;
        pick_slice = slice_len[pick_idx*SLICE_W +: SLICE_W];
        own_slice  = slice_len[own_q*SLICE_W +: SLICE_W];
        if (pick_slice < LIM_MIN) begin
            pick_slice = LIM_MIN;
        end
        if (own_slice < LIM_MIN) begin
            own_slice = LIM_MIN;
        end
        own_req = req[own_q];
        others  = |(req & ~(N'(1) << own_q));
        at_lim  = (cnt_q == {1'b0, lim_q});
    end

    // Next-state, slice counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        own_d    = own_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        expire   = 1'b0;
        gnt_d    = '0;
        gnt_id_d = '0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    own_d   = pick_idx;
                    cnt_d   = CNT_ONE;
                    lim_d   = pick_slice;
                end
            end
            ARB_BUSY: begin
                if (!own_req) begin
                    ptr_d = own_inc;
                    if (pick_any) begin
                        own_d = pick_idx;
                        cnt_d = CNT_ONE;
                        lim_d = pick_slice;
                    end else begin
                        state_d = ARB_IDLE;
                        own_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (!at_lim) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
`ifdef RR_ARB_LOCK_EN
                    expire = !lock;
`else
                    expire = 1'b1;
`endif
                end

                if (expire) begin
                    if (others) begin
                        ptr_d = own_inc;
                        own_d = pick_idx;
                        lim_d = pick_slice;
                    end else begin
                        lim_d = own_slice;
                    end
                    cnt_d = CNT_ONE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (state_d == ARB_BUSY) begin
            gnt_d          = '0;
            gnt_d[own_d]   = 1'b1;
            gnt_id_d       = own_d;
        end
    end

    // State, counters and glitch-free output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            gnt     <= gnt_d;
            gnt_id  <= gnt_id_d;
            gnt_vld <= (state_d == ARB_BUSY);
        end
    end

endmodule

// File: doc/rr_slice_arbiter.md
# rr_slice_arbiter

Parametrised N-way round-robin arbiter with a per-requester, run-time programmable time slice. It is the next-generation arbiter for shared-resource access. Each requester may hold the grant for up to its programmed number of consecutive cycles, after which the grant rotates to the next active requester. Outputs are registered (glitch-free), and hand-off between owners is back-to-back with no idle cycle.

## Interface
- N, 4: number of requesters (2..16).
- SLICE_W, 4: width of each slice-length field.
- ID_W, $clog2(N): width of gnt_id.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  request vector; bit i held high while requester i wants the resource.
- slice_len  in  N*SLICE_W  packed slice lengths; field i = bits [i*SLICE_W +: SLICE_W].
- lock  in  1  present only with RR_ARB_LOCK_EN; owner requests slice extension.
- gnt  out  N  registered one-hot grant, or all-zero.
- gnt_id  out  ID_W  index of the current owner; 0 when gnt_vld=0.
- gnt_vld  out  1  high when any gnt bit is set.

## Operation
- Two states:
  - IDLE: no owner.
  - BUSY: owner k, with a slice counter cnt and a latched slice limit lim.
- Rotation pointer ptr (reset 0): the search for the next owner starts at ptr and wraps modulo N. On every hand-off from owner k, ptr ← (k+1) mod N.
- IDLE: if req≠0, go to BUSY and select the first set req bit at or after ptr. Set cnt←1 and lim←max(slice_len[k],1). If req=0, stay IDLE.
- BUSY, req[k]=0: select the next requester after k. If none, go to IDLE.
- BUSY, req[k]=1, cnt<lim: keep owner k; cnt←cnt+1.
- BUSY, req[k]=1, cnt==lim:
  - If any other req bit is set, hand off to the next requester after k.
  - Otherwise keep k, start a fresh slice (cnt←1), and re-latch lim.
- On every new grant, slice_len is sampled into lim. Changes to slice_len mid-slice have no effect until the next slice.
- slice_len=0 is treated as 1 (pure round robin for that requester).
- cnt is SLICE_W+1 bits wide and never wraps; lim is bounded by 2^SLICE_W−1.

## Timing
- Reset: gnt=0, gnt_id=0, gnt_vld=0, state=IDLE, ptr=0, cnt=0.
- Latency:
  - A req sampled high at edge t in IDLE gives gnt valid after edge t (visible in cycle t+1).
  - A drop of req[k] sampled at edge t removes or moves the grant at edge t.
- Maximum contiguous ownership under contention is lim cycles.
- Worst-case wait for requester i is the sum of the other requesters' lims.
- Hand-off is always direct: gnt moves from bit k to bit j in one edge, never through zero, whenever another req is pending.
- Simultaneous events:
  - req[k] drops on the same edge that cnt==lim: treated as a drop.
  - A new req arriving on the hand-off edge participates in that selection.
- Asynchronous reset mid-grant clears all outputs immediately. After release, arbitration restarts from ptr=0.

## Configuration
- RR_ARB_LOCK_EN defined:
  - The lock port exists.
  - In BUSY with req[k]=1 and lock=1, slice expiry is suppressed; cnt saturates at lim and owner k keeps the grant.
  - lock has no effect in IDLE or when req[k]=0.
  - When lock deasserts with cnt==lim, the normal expiry rule applies at the next edge.
- RR_ARB_LOCK_EN undefined: the lock port and its logic are absent; slice expiry is always enforced.

## Structure
- Package rr_arb_pkg holds:
  - state enum {ARB_IDLE, ARB_BUSY};
  - a function next_req(req, start) returning the first set index at or after start, modulo N;
  - the constant MIN_SLICE=1.
- One sub-module, rr_prio_pick: a combinational masked priority picker (req, ptr → one-hot, index, any). It is instantiated once and shared by the IDLE and hand-off paths.

## Test plan
- Reset then req=4'b0101, all slices=2: gnt sequence 0001,0001,0100,0100,0001,… with no zero cycles.
- Single requester req=4'b0010, slice=3: gnt=0010 held continuously; cnt wraps 1→3→1 internally; gnt_vld stays 1.
- Slices {1,2,3,4}, req=4'b1111: repeating grant pattern of 1×bit0, 2×bit1, 3×bit2, 4×bit3; each period is 10 cycles.
- Owner drops req mid-slice (bit1 at cnt=1 of 3, req=4'b1011): gnt moves to 1000 at the same edge; ptr=2.
- slice_len changed from 4 to 1 mid-slice for the owner: the current slice still lasts 4 cycles; the next grant to it lasts 1.
- RR_ARB_LOCK_EN, req=4'b0011, slice=2, lock held 5 cycles: bit0 owns 5 cycles, then gnt=0010 the edge after lock falls. Reset asserted mid-grant: outputs are 0 immediately.
